// File: rtl/regfile_sb.sv
// Multi-port register file with bypassed reads, two write-back ports and a busy scoreboard.
// Register 0 always reads zero and is never marked busy.
module regfile_sb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH_B = 5,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned NRD     = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NRD*DEPTH_B-1:0] rf_ra,
    output logic [NRD*WIDTH-1:0]   rf_rd,
    output logic [NRD-1:0]         rf_busy,
    input  logic                   rf_we0,
    input  logic                   rf_we1,
    input  logic [DEPTH_B-1:0]     rf_wa0,
    input  logic [DEPTH_B-1:0]     rf_wa1,
    input  logic [WIDTH-1:0]       rf_wd0,
    input  logic [WIDTH-1:0]       rf_wd1,
    input  logic                   iss_valid,
    input  logic [DEPTH_B-1:0]     iss_wa,
    output logic [DEPTH_B:0]       busy_cnt,
    input  logic [DEPTH_B-1:0]     debug_reg_ra,
    output logic [WIDTH-1:0]       debug_reg_rd
);

    localparam logic [DEPTH_B:0] CntOne = (DEPTH_B + 1)'(1);

    logic [WIDTH-1:0] reg_file [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH_B:0] cnt_next;

    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = rf_we0 && (rf_wa0 != '0) && (32'(rf_wa0) < DEPTH);
    assign wr1_ok = rf_we1 && (rf_wa1 != '0) && (32'(rf_wa1) < DEPTH);

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < DEPTH; a++) begin
                reg_file[a] <= '0;
            end
        end else begin
            if (wr0_ok) reg_file[rf_wa0] <= rf_wd0;
            if (wr1_ok) reg_file[rf_wa1] <= rf_wd1;
        end
    end

    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        cnt_next = busy_cnt;
        for (int a = 1; a < DEPTH; a++) begin
            set_vec[a] = iss_valid && (iss_wa == DEPTH_B'(a));
            clr_vec[a] = (rf_we0 && (rf_wa0 == DEPTH_B'(a))) ||
                         (rf_we1 && (rf_wa1 == DEPTH_B'(a)));
            // Counter tracks popcount(busy) by only counting real transitions.
            if (set_vec[a] && !busy[a]) begin
                cnt_next = cnt_next + CntOne;
            end else if (clr_vec[a] && !set_vec[a] && busy[a]) begin
                cnt_next = cnt_next - CntOne;
            end
        end
        busy_next = (busy & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    always_comb begin
        logic [DEPTH_B-1:0] ra;
        logic               hit0;
        logic               hit1;
        rf_rd   = '0;
        rf_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra   = rf_ra[i*DEPTH_B +: DEPTH_B];
            hit0 = rf_we0 && (rf_wa0 == ra);
            hit1 = rf_we1 && (rf_wa1 == ra);
            if (ra == '0) begin
                rf_rd[i*WIDTH +: WIDTH] = '0;
            end else if (hit1) begin
                rf_rd[i*WIDTH +: WIDTH] = rf_wd1;
            end else if (hit0) begin
                rf_rd[i*WIDTH +: WIDTH] = rf_wd0;
            end else if (32'(ra) < DEPTH) begin
                rf_rd[i*WIDTH +: WIDTH] = reg_file[ra];
            end
            // A bypassed source is already satisfied, so no stall.
            if ((ra != '0) && (32'(ra) < DEPTH) && !hit0 && !hit1) begin
                rf_busy[i] = busy[ra];
            end
        end
    end

    always_comb begin
        debug_reg_rd = '0;
        if (32'(debug_reg_ra) < DEPTH) begin
            debug_reg_rd = reg_file[debug_reg_ra];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_sb;

    localparam int W   = 32;
    localparam int AB  = 5;
    localparam int D   = 32;
    localparam int NRD = 2;

    logic              clk;
    logic              rstn;
    logic [NRD*AB-1:0] rf_ra;
    logic [NRD*W-1:0]  rf_rd;
    logic [NRD-1:0]    rf_busy;
    logic              rf_we0, rf_we1;
    logic [AB-1:0]     rf_wa0, rf_wa1;
    logic [W-1:0]      rf_wd0, rf_wd1;
    logic              iss_valid;
    logic [AB-1:0]     iss_wa;
    logic [AB:0]       busy_cnt;
    logic [AB-1:0]     debug_reg_ra;
    logic [W-1:0]      debug_reg_rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mrf [D];
    bit           mbusy [D];

    regfile_sb #(.WIDTH(W), .DEPTH_B(AB), .DEPTH(D), .NRD(NRD)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rf_ra        (rf_ra),
        .rf_rd        (rf_rd),
        .rf_busy      (rf_busy),
        .rf_we0       (rf_we0),
        .rf_we1       (rf_we1),
        .rf_wa0       (rf_wa0),
        .rf_wa1       (rf_wa1),
        .rf_wd0       (rf_wd0),
        .rf_wd1       (rf_wd1),
        .iss_valid    (iss_valid),
        .iss_wa       (iss_wa),
        .busy_cnt     (busy_cnt),
        .debug_reg_ra (debug_reg_ra),
        .debug_reg_rd (debug_reg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int popcnt();
        int c = 0;
        for (int a = 0; a < D; a++) c += int'(mbusy[a]);
        return c;
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AB-1:0] a);
        if (a == 0) return '0;
        if (rf_we1 && rf_wa1 == a) return rf_wd1;
        if (rf_we0 && rf_wa0 == a) return rf_wd0;
        return mrf[a];
    endfunction

    function automatic logic exp_busy(input logic [AB-1:0] a);
        if (a == 0) return 1'b0;
        if ((rf_we1 && rf_wa1 == a) || (rf_we0 && rf_wa0 == a)) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic logic [W-1:0] get_rd(input int i);
        return rf_rd[i*W +: W];
    endfunction

    task automatic set_ra(input int i, input logic [AB-1:0] a);
        rf_ra[i*AB +: AB] = a;
    endtask

    task automatic idle();
        rf_we0 = 0; rf_we1 = 0; rf_wa0 = 0; rf_wa1 = 0;
        rf_wd0 = 0; rf_wd1 = 0; iss_valid = 0; iss_wa = 0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < D; a++) begin
            mrf[a]   = '0;
            mbusy[a] = 1'b0;
        end
    endtask

    // Advance one clock, updating the model with the inputs the DUT sees at the edge.
    task automatic tick();
        if (rstn) begin
            for (int a = 1; a < D; a++) begin
                if (iss_valid && iss_wa == AB'(a)) mbusy[a] = 1'b1;
                else if ((rf_we0 && rf_wa0 == AB'(a)) || (rf_we1 && rf_wa1 == AB'(a)))
                    mbusy[a] = 1'b0;
            end
            if (rf_we0 && rf_wa0 != 0) mrf[rf_wa0] = rf_wd0;
            if (rf_we1 && rf_wa1 != 0) mrf[rf_wa1] = rf_wd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 0; idle(); rf_ra = '0; debug_reg_ra = '0; model_reset();
        repeat (3) tick();
        rstn = 1;
        rf_we0 = 1; rf_wa0 = 5; rf_wd0 = 32'h0000_1234;
        tick();
        idle(); iss_valid = 1; iss_wa = 6;
        tick();
        idle();
        #2 rstn = 0;
        model_reset();
        set_ra(0, 5); set_ra(1, 6); debug_reg_ra = 5;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd0: got %h expected %h", get_rd(0), 32'h0);
        end
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt);
        end
        n_checks++;
        if (rf_busy !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 00", rf_busy);
        end
        n_checks++;
        if (debug_reg_rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_dbg: got %h expected 0", debug_reg_rd);
        end
        rf_we0 = 1; rf_wa0 = 5; rf_wd0 = 32'h0000_00AA;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0000_00AA) begin
            n_fail++; $display("FAIL reset_bypass: got %h expected %h", get_rd(0), 32'hAA);
        end
        tick();
        idle();
        rstn = 1;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0) begin
            n_fail++; $display("FAIL reset_release_x5: got %h expected 0", get_rd(0));
        end
        tick();
        n_checks++;
        if (get_rd(0) !== 32'h0) begin
            n_fail++; $display("FAIL reset_after_edge_x5: got %h expected 0", get_rd(0));
        end
    endtask

    task automatic test_write_bypass();
        idle();
        rf_we0 = 1; rf_wa0 = 5; rf_wd0 = 32'hDEAD_BEEF; set_ra(0, 5); debug_reg_ra = 5;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_bypass: got %h expected DEADBEEF", get_rd(0));
        end
        n_checks++;
        if (debug_reg_rd !== 32'h0) begin
            n_fail++; $display("FAIL wr_dbg_nobypass: got %h expected 0", debug_reg_rd);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_array: got %h expected DEADBEEF", get_rd(0));
        end
        n_checks++;
        if (debug_reg_rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_dbg: got %h expected DEADBEEF", debug_reg_rd);
        end
    endtask

    task automatic test_dual_collision();
        idle();
        rf_we0 = 1; rf_we1 = 1; rf_wa0 = 7; rf_wa1 = 7;
        rf_wd0 = 32'h11; rf_wd1 = 32'h22; set_ra(0, 7); debug_reg_ra = 7;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h22) begin
            n_fail++; $display("FAIL dual_bypass: got %h expected 22", get_rd(0));
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h22) begin
            n_fail++; $display("FAIL dual_array: got %h expected 22", get_rd(0));
        end
        n_checks++;
        if (debug_reg_rd !== 32'h22) begin
            n_fail++; $display("FAIL dual_dbg: got %h expected 22", debug_reg_rd);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1; iss_wa = 3; set_ra(1, 3);
        #1;
        n_checks++;
        if (rf_busy[1] !== 1'b0) begin
            n_fail++; $display("FAIL sb_issue_cycle: got %b expected 0", rf_busy[1]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rf_busy[1] !== 1'b1) begin
            n_fail++; $display("FAIL sb_busy: got %b expected 1", rf_busy[1]);
        end
        n_checks++;
        if (busy_cnt !== 6'd1) begin
            n_fail++; $display("FAIL sb_cnt1: got %0d expected 1", busy_cnt);
        end
        tick();
        rf_we1 = 1; rf_wa1 = 3; rf_wd1 = 32'hCAFE_0003;
        #1;
        n_checks++;
        if (rf_busy[1] !== 1'b0) begin
            n_fail++; $display("FAIL sb_wb_cycle: got %b expected 0", rf_busy[1]);
        end
        n_checks++;
        if (get_rd(1) !== 32'hCAFE_0003) begin
            n_fail++; $display("FAIL sb_wb_bypass: got %h expected CAFE0003", get_rd(1));
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL sb_cnt0: got %0d expected 0", busy_cnt);
        end
        // Minimum issue-to-writeback distance of one cycle.
        iss_valid = 1; iss_wa = 9; set_ra(0, 9);
        tick();
        idle();
        rf_we0 = 1; rf_wa0 = 9; rf_wd0 = 32'h9999;
        #1;
        n_checks++;
        if (rf_busy[0] !== 1'b0 || busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL sb_min_dist: got busy=%b cnt=%0d expected busy=0 cnt=1",
                     rf_busy[0], busy_cnt);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL sb_min_dist_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_set_clear();
        idle();
        iss_valid = 1; iss_wa = 4;
        tick();
        idle();
        iss_valid = 1; iss_wa = 4; rf_we0 = 1; rf_wa0 = 4; rf_wd0 = 32'h44;
        tick();
        idle(); set_ra(0, 4);
        #1;
        n_checks++;
        if (rf_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL setclr: got busy=%b cnt=%0d expected busy=1 cnt=1",
                     rf_busy[0], busy_cnt);
        end
        rf_we0 = 1; rf_wa0 = 4; rf_wd0 = 32'h45;
        tick();
        idle();
        // Register 0 is never set, cleared or written.
        iss_valid = 1; iss_wa = 0; rf_we0 = 1; rf_wa0 = 0; rf_wd0 = 32'hFFFF_FFFF;
        set_ra(0, 0); debug_reg_ra = 0;
        #1;
        n_checks++;
        if (get_rd(0) !== 32'h0) begin
            n_fail++; $display("FAIL x0_bypass: got %h expected 0", get_rd(0));
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || rf_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_cnt: got cnt=%0d busy=%b expected 0/0", busy_cnt, rf_busy[0]);
        end
        n_checks++;
        if (get_rd(0) !== 32'h0 || debug_reg_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_read: got %h/%h expected 0/0", get_rd(0), debug_reg_rd);
        end
    endtask

    task automatic test_async_reset();
        idle();
        for (int k = 1; k <= 3; k++) begin
            iss_valid = 1; iss_wa = AB'(k);
            tick();
        end
        idle(); set_ra(0, 1); set_ra(1, 2);
        #1;
        n_checks++;
        if (busy_cnt !== 6'd3) begin
            n_fail++; $display("FAIL arst_pre_cnt: got %0d expected 3", busy_cnt);
        end
        #1 rstn = 0;
        model_reset();
        #1;
        n_checks++;
        if (busy_cnt !== 6'd0 || rf_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_immediate: got cnt=%0d busy=%b expected 0/00", busy_cnt, rf_busy);
        end
        tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_random();
        int ra;
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 2) != 0) begin
                ra = int'($urandom_range(1, D - 1));
                if (!mbusy[ra]) begin
                    iss_valid = 1; iss_wa = AB'(ra);
                end
            end
            rf_we0 = 1'($urandom_range(0, 1));
            rf_we1 = 1'($urandom_range(0, 1));
            rf_wa0 = AB'($urandom_range(0, D - 1));
            rf_wa1 = ($urandom_range(0, 5) == 0) ? rf_wa0 : AB'($urandom_range(0, D - 1));
            rf_wd0 = $urandom;
            rf_wd1 = $urandom;
            for (int i = 0; i < NRD; i++) set_ra(i, AB'($urandom_range(0, D - 1)));
            debug_reg_ra = AB'($urandom_range(0, D - 1));
            #1;
            for (int i = 0; i < NRD; i++) begin
                n_checks++;
                if (get_rd(i) !== exp_rd(rf_ra[i*AB +: AB])) begin
                    n_fail++;
                    $display("FAIL rnd_rd%0d cyc %0d: got %h expected %h", i, c, get_rd(i),
                             exp_rd(rf_ra[i*AB +: AB]));
                end
                n_checks++;
                if (rf_busy[i] !== exp_busy(rf_ra[i*AB +: AB])) begin
                    n_fail++;
                    $display("FAIL rnd_busy%0d cyc %0d: got %b expected %b", i, c, rf_busy[i],
                             exp_busy(rf_ra[i*AB +: AB]));
                end
            end
            n_checks++;
            if (int'(busy_cnt) != popcnt()) begin
                n_fail++;
                $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", c, busy_cnt, popcnt());
            end
            n_checks++;
            if (debug_reg_rd !== mrf[debug_reg_ra]) begin
                n_fail++;
                $display("FAIL rnd_dbg cyc %0d: got %h expected %h", c, debug_reg_rd,
                         mrf[debug_reg_ra]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_dual_collision();
        test_scoreboard();
        test_set_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated busy scoreboard, the successor to the single-write, two-read pipeline register file. It sits between decode/issue and writeback. It provides NRD bypassed read ports and two write-back ports, and tracks which registers have an in-flight producer. Per-port stall hints go to the hazard unit. Register 0 is hardwired to zero and is never busy.

## Interface
- WIDTH, 32, data width in bits
- DEPTH_B, 5, address width
- DEPTH, 32, number of registers (≤ 2^DEPTH_B)
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- rf_ra  in  NRD*DEPTH_B  read addresses, port i at bits [i*DEPTH_B +: DEPTH_B]
- rf_rd  out  NRD*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH]
- rf_busy  out  NRD  port i source has an outstanding producer not being written this cycle
- rf_we0, rf_we1  in  1 each  write-back enables
- rf_wa0, rf_wa1  in  DEPTH_B each  write-back addresses
- rf_wd0, rf_wd1  in  WIDTH each  write-back data
- iss_valid  in  1  an instruction with a destination issues this cycle
- iss_wa  in  DEPTH_B  destination of the issuing instruction
- busy_cnt  out  DEPTH_B+1  number of registers currently marked busy
- debug_reg_ra  in  DEPTH_B  debug read address
- debug_reg_rd  out  WIDTH  debug read data, array value only, no bypass

## Operation
- State: data array reg_file[DEPTH], busy vector busy[DEPTH].
- Reset (rstn=0, async): every register is 0, busy is all 0, busy_cnt=0. Combinational outputs follow: rf_busy=0, and rf_rd is the bypass value if any write is enabled, else 0.
- Write: at posedge, if rf_weK && rf_waK≠0, then reg_file[rf_waK] ← rf_wdK.
  - If both ports target the same nonzero address, port 1 wins and port 0's data is dropped.
  - Writes to address 0 are ignored.
- Read port i (combinational), in priority order:
  - ra=0 → 0
  - rf_we1 && rf_wa1=ra → rf_wd1
  - rf_we0 && rf_wa0=ra → rf_wd0
  - otherwise reg_file[ra]
- Scoreboard update at posedge:
  - busy_next[a] = (busy[a] & ~clr[a]) | set[a]
  - clr[a] = (rf_we0 && rf_wa0=a) || (rf_we1 && rf_wa1=a)
  - set[a] = iss_valid && iss_wa=a
  - a=0 is excluded from both set and clear.
  - Same-cycle set and clear on one address → busy=1, because the new producer wins.
- Stall hint: rf_busy[i] = busy[ra_i] && ra_i≠0 && no enabled write to ra_i this cycle.
  - Bypass satisfies the read, so no stall is signalled for it.
  - A same-cycle issue to ra_i does not raise rf_busy[i].
- busy_cnt is a registered counter updated each cycle by +1 for an effective set of a non-busy register, and −1 for each effective clear of a busy register that is not simultaneously set.
  - busy_cnt must always equal popcount(busy).
  - Range is 0..DEPTH−1.
- Usage contract: the issue stage guarantees at most one outstanding producer per register (WAW is stalled upstream). A write to a non-busy register still updates data and leaves busy at 0.

## Timing
- Read latency 0 (combinational from rf_ra, write ports, and array).
- Write latency 1: data is visible from the array on the cycle after the enable edge, and is bypassed in the enable cycle itself.
- busy and busy_cnt change 1 cycle after iss_valid or the write enable.
- Issue-to-writeback minimum distance is 1 cycle. For issue at cycle n and write at n+1, busy=1 during n+1 only, and rf_busy is 0 during n+1 via the bypass.
- Reset deassertion mid-operation: state remains zero until the first posedge after rstn rises. Inputs at that edge are honoured normally.
- Reset assertion mid-operation discards all pending busy bits immediately, without waiting for a clock.

## Test plan
- Reset and read: assert rstn=0 with array preloaded. Required: all rf_rd=0, busy_cnt=0, rf_busy=0. Release reset, then read x5 → 0.
- Write/bypass: rf_we0=1, wa0=5, wd0=0xDEADBEEF, ra0=5. Required: rf_rd port 0=0xDEADBEEF in the same cycle, and the same value from the array next cycle with we0=0.
- Dual write collision: we0/we1=1, both wa=7, wd0=0x11, wd1=0x22. Required: bypass read=0x22, and array holds 0x22 next cycle.
- Scoreboard: issue wa=3 at cycle 0, then read ra1=3 at cycle 1. Required: rf_busy[1]=1 and busy_cnt=1. Write wa1=3 at cycle 2. Required: rf_busy[1]=0 that cycle, and busy_cnt=0 at cycle 3.
- Simultaneous set and clear: busy[4]=1, then iss_wa=4 and rf_wa0=4 in the same cycle. Required: busy[4] stays 1 and busy_cnt is unchanged. Separately, iss_wa=0 or writing x0 → busy_cnt stays 0 and x0 reads 0.
- Async reset mid-run: with busy_cnt=3, pull rstn low between edges. Required: busy_cnt=0 and rf_busy=0 immediately, without waiting for a clock edge.
